// File: rtl/fetch_queue.sv
// Fetch stage: sequential PC requests over a valid/ready memory port feeding an in-order
// prefetch queue to decode. Redirects flush the queue and drop any responses still outstanding.
module fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instrD,
  output logic [ADDR_W-1:0]  pcD,
  output logic               validD,
  input  logic               readyD
);

  localparam int unsigned       PtrW   = $clog2(DEPTH);
  localparam int unsigned       CntW   = PtrW + 1;
  localparam logic [CntW-1:0]   DepthC = CntW'(DEPTH);
  localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(4);

  logic [ADDR_W-1:0]  pcF_q, pcF_d;
  logic [ADDR_W-1:0]  rspPc_q, rspPc_d;
  logic [CntW-1:0]    inflight_q, inflight_d;
  logic [CntW-1:0]    discard_q, discard_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [PtrW-1:0]    rdPtr_q, rdPtr_d;
  logic [PtrW-1:0]    wrPtr_q, wrPtr_d;
  logic [INSTR_W-1:0] instrMem_q [DEPTH];
  logic [ADDR_W-1:0]  pcMem_q    [DEPTH];

  logic              accept;
  logic              rspTake;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] redirectAligned;
  logic              unusedRedirectLow;

  assign unusedRedirectLow = ^redirect_pc[1:0];
  assign redirectAligned   = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Pending non-discarded responses plus queued entries must fit in the queue.
  assign imem_req_valid = reset & ~redirect & (inflight_q < DepthC) &
                          (((inflight_q - discard_q) + count_q) < DepthC);
  assign imem_req_addr  = pcF_q;
  assign accept         = imem_req_valid & imem_req_ready;

  assign rspTake = imem_rsp_valid & (inflight_q != '0);
  assign push    = rspTake & (discard_q == '0);
  assign validD  = (count_q != '0);
  assign pop     = validD & readyD;
  assign instrD  = instrMem_q[rdPtr_q];
  assign pcD     = pcMem_q[rdPtr_q];

  always_comb begin
    pcF_d      = pcF_q;
    rspPc_d    = rspPc_q;
    inflight_d = inflight_q + CntW'(accept) - CntW'(rspTake);
    discard_d  = discard_q;
    count_d    = count_q;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    if (redirect) begin
      pcF_d     = redirectAligned;
      rspPc_d   = redirectAligned;
      discard_d = inflight_q - CntW'(rspTake);
      count_d   = '0;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
    end else begin
      if (accept) begin
        pcF_d = pcF_q + PcStep;
      end
      if (rspTake && (discard_q != '0)) begin
        discard_d = discard_q - CntW'(1);
      end
      if (push) begin
        wrPtr_d = wrPtr_q + PtrW'(1);
        rspPc_d = rspPc_q + PcStep;
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcF_q      <= RESET_PC;
      rspPc_q    <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
    end else begin
      pcF_q      <= pcF_d;
      rspPc_q    <= rspPc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
    end
  end

  // Storage is cleared on reset so instrD/pcD read as zero until the first push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instrMem_q[i] <= '0;
        pcMem_q[i]    <= '0;
      end
    end else if (push && !redirect) begin
      instrMem_q[wrPtr_q] <= imem_rsp_data;
      pcMem_q[wrPtr_q]    <= rspPc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: an in-order variable-latency memory model drives the DUT and a
// queue-based reference model of outstanding requests and queued instructions checks every cycle.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic        readyD;

  always #5 clk = ~clk;

  fetch_queue #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .instrD        (instrD),
    .pcD           (pcD),
    .validD        (validD),
    .readyD        (readyD)
  );

  int nChecks = 0;
  int nFail   = 0;

  // Reference model: outstanding requests (address, dropped flag) and queued decode entries.
  logic [31:0] oAddr[$];
  bit          oDrop[$];
  logic [31:0] qInstr[$];
  logic [31:0] qPc[$];
  logic [31:0] mPcF;

  // Memory model: accepted addresses with the cycle their response is due.
  logic [31:0] mqAddr[$];
  int          mqDue[$];
  int          lastDue;
  int          cyc;

  // Stimulus knobs (percent, redirect in per-mille).
  int          pReadyD, pReqReady, latMin, latMax, pRedirect, pSpur;
  logic        forceRedirect;
  logic [31:0] forcePc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int kept();
    int k = 0;
    foreach (oDrop[i]) if (!oDrop[i]) k++;
    return k;
  endfunction

  task automatic clearModel();
    oAddr.delete();
    oDrop.delete();
    qInstr.delete();
    qPc.delete();
    mqAddr.delete();
    mqDue.delete();
    mPcF    = RESET_PC;
    lastDue = cyc;
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic step();
    logic        expReqValid;
    logic        rspTake;
    logic        mAccept;
    logic        dAccept;
    logic        spur;
    logic [31:0] a;
    bit          d;
    int          due;
    readyD         = ($urandom_range(99) < pReadyD);
    imem_req_ready = ($urandom_range(99) < pReqReady);
    redirect       = forceRedirect || ($urandom_range(999) < pRedirect);
    redirect_pc    = forceRedirect ? forcePc : $urandom;
    spur           = 1'b0;
    if (mqAddr.size() > 0 && mqDue[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mqAddr[0] ^ DATA_KEY;
    end else if (mqAddr.size() == 0 && $urandom_range(99) < pSpur) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
      spur           = 1'b1;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    expReqValid = !redirect && (oAddr.size() < DEPTH) && (kept() + qInstr.size() < DEPTH);
    check("req_valid", 64'(imem_req_valid), 64'(expReqValid));
    check("req_addr", 64'(imem_req_addr), 64'(mPcF));
    check("validD", 64'(validD), 64'(qInstr.size() != 0));
    if (qInstr.size() != 0) begin
      check("pcD", 64'(pcD), 64'(qPc[0]));
      check("instrD", 64'(instrD), 64'(qInstr[0]));
    end

    rspTake = imem_rsp_valid && (oAddr.size() > 0);
    mAccept = expReqValid && imem_req_ready;
    dAccept = imem_req_valid && imem_req_ready;
    if (redirect) begin
      if (rspTake) begin
        void'(oAddr.pop_front());
        void'(oDrop.pop_front());
      end
      foreach (oDrop[i]) oDrop[i] = 1'b1;
      qInstr.delete();
      qPc.delete();
      mPcF = {redirect_pc[31:2], 2'b00};
    end else begin
      if (qInstr.size() != 0 && readyD) begin
        void'(qInstr.pop_front());
        void'(qPc.pop_front());
      end
      if (rspTake) begin
        a = oAddr.pop_front();
        d = oDrop.pop_front();
        if (!d) begin
          qInstr.push_back(a ^ DATA_KEY);
          qPc.push_back(a);
        end
      end
      if (mAccept) begin
        oAddr.push_back(mPcF);
        oDrop.push_back(1'b0);
        mPcF = mPcF + 32'd4;
      end
    end

    if (imem_rsp_valid && !spur) begin
      void'(mqAddr.pop_front());
      void'(mqDue.pop_front());
    end
    if (dAccept) begin
      due = cyc + int'($urandom_range(latMax, latMin));
      if (due <= lastDue) due = lastDue + 1;
      mqAddr.push_back(imem_req_addr);
      mqDue.push_back(due);
      lastDue = due;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState();
    check("rst_req_valid", 64'(imem_req_valid), 64'(0));
    check("rst_validD", 64'(validD), 64'(0));
    check("rst_instrD", 64'(instrD), 64'(0));
    check("rst_pcD", 64'(pcD), 64'(0));
    check("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
  endtask

  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    readyD         = 1'b0;
    forceRedirect  = 1'b0;
    forcePc        = '0;
    cyc            = 0;
    clearModel();
    @(posedge clk);
    #1;
    checkResetState();
    reset = 1'b1;

    // Streaming with a 1-cycle memory and an always-ready decoder.
    pReadyD = 100; pReqReady = 100; latMin = 1; latMax = 1; pRedirect = 0; pSpur = 0;
    repeat (30) step();

    // Decoder stalled until the queue fills, then drains.
    pReadyD = 0;
    repeat (12) step();
    pReadyD = 100;
    repeat (12) step();

    // 3-cycle memory, redirect to a misaligned target while requests are in flight.
    latMin = 3; latMax = 3;
    repeat (6) step();
    forceRedirect = 1'b1; forcePc = 32'h0000_0102;
    step();
    forceRedirect = 1'b0;
    repeat (15) step();

    // Memory refuses requests for a while; address must hold.
    pReqReady = 0;
    repeat (5) step();
    pReqReady = 100;
    repeat (5) step();

    // Mixed random traffic including redirects and spurious responses.
    pReadyD = 60; pReqReady = 70; latMin = 1; latMax = 5; pRedirect = 50; pSpur = 20;
    repeat (3000) step();

    // Asynchronous reset with work in flight and entries queued.
    pReadyD = 0; pReqReady = 100; latMin = 4; latMax = 4; pRedirect = 0; pSpur = 0;
    forceRedirect = 1'b1; forcePc = 32'h0000_2000;
    step();
    forceRedirect = 1'b0;
    for (int i = 0; i < 40 && !(qInstr.size() >= 2 && oAddr.size() >= 2); i++) step();
    check("reset_setup_reached", 64'(qInstr.size() >= 2 && oAddr.size() >= 2), 64'(1));
    reset = 1'b0;
    #1;
    checkResetState();
    clearModel();
    @(posedge clk);
    #1;
    reset = 1'b1;
    pReadyD = 100; latMin = 1; latMax = 1;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised successor to the single-entry PC register plus IF/ID register of the pipeline fetch stage. It holds a fetch PC and issues sequential instruction requests over a valid/ready memory port that may have variable latency. Returned instructions are kept in a DEPTH-entry in-order prefetch queue that feeds the decode stage. A redirect from decode or execute (branch, jal, jalr) flushes the queue and discards any in-flight responses.

Parameters:
ADDR_W, 32, width of PCs and request addresses
INSTR_W, 32, instruction width
DEPTH, 4, queue entries; must be a power of 2 and >= 2
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  request address (word aligned)
imem_rsp_valid  in  1  response valid; responses return in request order
imem_rsp_data  in  INSTR_W  response instruction
redirect  in  1  flush and restart fetch
redirect_pc  in  ADDR_W  new fetch PC
instrD  out  INSTR_W  head instruction to decode
pcD  out  ADDR_W  PC of head instruction
validD  out  1  head entry valid
readyD  in  1  decode consumes the head entry (stall = 0)

Behaviour:
- Internal state:
  - pcF: next PC to request.
  - rsp_pc: PC of the next non-discarded response.
  - inflight: accepted but not yet returned requests, 0..DEPTH.
  - discard: responses still to be dropped, always <= inflight.
  - count: queue occupancy, 0..DEPTH.
  - rd_ptr, wr_ptr: log2(DEPTH)-bit pointers that wrap modulo DEPTH.
- Reset (reset = 0, asynchronous):
  - pcF and rsp_pc = RESET_PC; inflight, discard, count and both pointers = 0.
  - Outputs: imem_req_valid = 0, validD = 0, instrD = 0, pcD = 0, imem_req_addr = RESET_PC.
  - Reset may be asserted mid-operation. The memory is reset together with this block, so no stale responses arrive afterwards.
- Request:
  - imem_req_valid = !redirect & (inflight < DEPTH) & ((inflight - discard) + count < DEPTH).
  - imem_req_addr = pcF.
  - Accept = valid & ready. On accept: pcF += 4 (wraps modulo 2^ADDR_W) and inflight += 1.
  - While valid & !ready, imem_req_addr is held stable.
- Response (imem_rsp_valid = 1):
  - inflight -= 1 always.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise: write {imem_rsp_data, rsp_pc} at wr_ptr, then wr_ptr += 1, count += 1, rsp_pc += 4.
  - imem_rsp_valid while inflight = 0 is ignored.
- Decode side:
  - validD = (count != 0); instrD and pcD are the entry at rd_ptr.
  - Pop on validD & readyD: rd_ptr += 1, count -= 1.
  - Push and pop in the same cycle leave count unchanged.
  - When count = DEPTH, the request condition already blocks new requests, so a push never overflows.
- Latency:
  - Accepted response at edge t is visible on validD/instrD after edge t.
  - If imem_req_ready is 1 and the memory responds in the next cycle, sustained throughput is 1 instruction/cycle when readyD = 1.
- Redirect (redirect = 1 at an edge), takes priority over every other event:
  - count, rd_ptr and wr_ptr = 0; any simultaneous push or pop is cancelled (the head the decoder saw counts as consumed).
  - pcF and rsp_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - discard = inflight - imem_rsp_valid, i.e. every still-outstanding response is dropped.
  - No request is issued in the redirect cycle; fetch resumes the next cycle.
  - Back-to-back redirects are legal; the last one wins.
- Width rules:
  - inflight, discard and count are log2(DEPTH)+1 bits wide.
  - Compare arithmetic uses that width and never underflows because discard <= inflight.

Test Plan:
1. Reset release, imem_req_ready = 1, 1-cycle memory returning data = addr ^ 32'hA5A5_0000, readyD = 1 -> requests 0x0, 0x4, 0x8…; validD first high 2 cycles after first accept; pcD/instrD pairs match; one instruction per cycle.
2. readyD = 0, DEPTH = 4 -> exactly 4 requests accepted, then imem_req_valid = 0 with count = 4; set readyD = 1 -> drains 0x0..0xC in order and fetching resumes at 0x10.
3. Memory latency 3 cycles with 3 requests in flight; redirect to 0x0000_0102 -> the next 3 responses are dropped; next request address is 0x100; first pcD after redirect is 0x100.
4. Redirect in the same cycle as a response, a pop and a push -> queue empty next cycle; discard = inflight - 1; no stale entry ever reaches validD.
5. imem_req_ready = 0 for 5 cycles -> imem_req_valid stays 1 and imem_req_addr is held at the same value; pcF advances only on the accept cycle.
6. Assert reset with 2 requests in flight and 2 queued -> validD = 0 and imem_req_valid = 0 immediately (asynchronously); after release, fetch restarts at RESET_PC.
